// File: rtl/vram_ctrl.sv
// Text/attribute video RAM: one video read per ph0 rise, host command port, cursor, ranged fill, scroll base.
// Optional cursor blink is enabled by defining VRAM_CURSOR_BLINK_EN. RAM contents are undefined at power-up.
module vram_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned ROW_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ph0,
    input  logic              sec_in,
    input  logic              de_in,
    input  logic              hs_in,
    input  logic              vs_in,
    input  logic [ROW_W-1:0]  row_in,
    input  logic [ADDR_W-1:0] video_address,
    input  logic [ADDR_W-1:0] int_address,
    input  logic [5:0]        int_command,
    input  logic [DATA_W-1:0] int_data_in,
    output logic              ph1,
    output logic              sec_out,
    output logic              de_out,
    output logic              hs_out,
    output logic              vs_out,
    output logic [ROW_W-1:0]  row_out,
    output logic [DATA_W-1:0] vram_out,
    output logic              cursor,
    output logic [1:0]        state,
    output logic [DATA_W-1:0] int_data_out
);
    localparam logic [5:0] CMD_WRITE  = 6'b100011;
    localparam logic [5:0] CMD_READ   = 6'b010011;
    localparam logic [5:0] CMD_FILL   = 6'b110000;
    localparam logic [5:0] CMD_CURSOR = 6'b100001;
    localparam logic [5:0] CMD_BASE   = 6'b110001;
`ifdef VRAM_CURSOR_BLINK_EN
    localparam logic [5:0] CMD_BLINK  = 6'b100010;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2,
        ST_RDY  = 2'd3
    } state_t;

    state_t              st;
    logic [1:0]          ph0_det;
    logic [ADDR_W-1:0]   cursor_addr;
    logic [ADDR_W-1:0]   base;
    logic [ADDR_W-1:0]   ptr;
    logic [DATA_W-1:0]   fill_word;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic                slot;
    logic [ADDR_W-1:0]   phys;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                show;

    assign slot  = (ph0_det == 2'b01);
    assign phys  = video_address + base;
    assign state = st;

`ifdef VRAM_CURSOR_BLINK_EN
    logic blink;
    logic blink_enable;
    assign show = blink | ~blink_enable;
`else
    assign show = 1'b1;
`endif

    // Single RAM write port shared by fill steps and host writes; video slots block both.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ptr;
        mem_wdata = fill_word;
        if (!slot && st == ST_FILL) begin
            mem_we = 1'b1;
        end else if (!slot && st == ST_IDLE && int_command == CMD_WRITE) begin
            mem_we    = 1'b1;
            mem_waddr = int_address;
            mem_wdata = int_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= ST_IDLE;
            ph0_det      <= 2'b00;
            cursor_addr  <= '0;
            base         <= '0;
            ptr          <= '0;
            fill_word    <= '0;
            ph1          <= 1'b0;
            sec_out      <= 1'b0;
            de_out       <= 1'b0;
            hs_out       <= 1'b0;
            vs_out       <= 1'b0;
            row_out      <= '0;
            vram_out     <= '0;
            cursor       <= 1'b0;
            int_data_out <= '0;
`ifdef VRAM_CURSOR_BLINK_EN
            blink        <= 1'b1;
            blink_enable <= 1'b1;
`endif
        end else begin
            ph0_det <= {ph0_det[0], ph0};
            ph1     <= ph0_det[0];
            sec_out <= sec_in;
`ifdef VRAM_CURSOR_BLINK_EN
            if (sec_in && !sec_out) begin
                blink <= ~blink;
            end
`endif
            if (slot) begin
                vram_out <= mem[phys];
                cursor   <= (phys == cursor_addr) & show;
                de_out   <= de_in;
                hs_out   <= hs_in;
                vs_out   <= vs_in;
                row_out  <= row_in;
            end else begin
                // Host side only advances on non-video cycles; a held command simply runs one clk later.
                case (st)
                    ST_IDLE: begin
                        case (int_command)
                            CMD_WRITE: begin
                                cursor_addr <= int_address + ADDR_W'(1);
                                st          <= ST_DONE;
                            end
                            CMD_READ: begin
                                int_data_out <= mem[int_address];
                                st           <= ST_RDY;
                            end
                            CMD_FILL: begin
                                ptr         <= int_address;
                                fill_word   <= int_data_in;
                                cursor_addr <= int_address;
                                st          <= ST_FILL;
                            end
                            CMD_CURSOR: begin
                                cursor_addr <= int_address;
                                st          <= ST_DONE;
                            end
                            CMD_BASE: begin
                                base <= int_address;
                                st   <= ST_DONE;
                            end
`ifdef VRAM_CURSOR_BLINK_EN
                            CMD_BLINK: begin
                                blink_enable <= int_data_in[0];
                                st           <= ST_DONE;
                            end
`endif
                            default: ;
                        endcase
                    end
                    ST_FILL: begin
                        if (ptr == '1) begin
                            st <= ST_DONE;
                        end else begin
                            ptr <= ptr + ADDR_W'(1);
                        end
                    end
                    default: begin
                        if (int_command == '0) begin
                            st <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end
endmodule
